// File: rtl/fifo_lab_pkg.sv
// Shared types and constants for the FIFO lab write-side blocks.
//   state_e      : feeder FSM states
//   word_t       : 16-bit data word
//   LFSR_TAPS    : tap mask for x^16+x^14+x^13+x^11+1 (bits 15,13,12,10)
//   FIFO_DEPTH   : depth of the downstream FIFO
//   DEFAULT_SEED : LFSR reset/reload value
package fifo_lab_pkg;

   typedef enum logic [1:0] {IDLE, RUN, STALL, DONE} state_e;

   typedef logic [15:0] word_t;

   localparam word_t LFSR_TAPS    = 16'hB400;
   localparam int    FIFO_DEPTH   = 32;
   localparam word_t DEFAULT_SEED = 16'h0001;

endpackage

// File: rtl/lfsr_fifo_feeder_edge_sync_pulse.sv
// edge_sync_pulse: STAGES-flop synchroniser followed by a rising-edge
// detector. STAGES=0 skips synchronisation and only detects the edge.
// Ports:
//   clock   : system clock
//   reset   : asynchronous, active-low
//   d_i     : input level
//   pulse_o : one-cycle pulse on a rising edge of the (synchronised) level
module edge_sync_pulse #(
   parameter int STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic d_i,
   output logic pulse_o
);

   logic synced;
   logic prev_q;

   generate
      if (STAGES == 0) begin : g_direct
         assign synced = d_i;
      end else begin : g_sync
         logic [STAGES-1:0] sync_q;

         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               sync_q <= '0;
            end else begin
               sync_q[0] <= d_i;
               for (int i = 1; i < STAGES; i++) begin
                  sync_q[i] <= sync_q[i-1];
               end
            end
         end

         assign synced = sync_q[STAGES-1];
      end
   endgenerate

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) prev_q <= 1'b0;
      else        prev_q <= synced;
   end

   assign pulse_o = synced & ~prev_q;

endmodule

// File: rtl/lfsr_fifo_feeder.sv
// lfsr_fifo_feeder: write-side stage for the 32-entry FIFO. Pushes one
// Fibonacci-LFSR word per synchronised write tick while a burst runs,
// honouring fifo_full, enable, seed reload and a fixed burst length.
// Ports:
//   clock, reset  : system clock, asynchronous active-low reset
//   tick_in       : slow write tick, asynchronous to clock
//   start         : level, rising edge starts a burst
//   enable        : 0 freezes LFSR and pushes
//   seed_load     : active-low synchronous reload of SEED, aborts burst
//   fifo_full     : FIFO full flag
//   wr_en/wr_data : one-cycle push strobe and pushed word
//   lfsr_q        : current LFSR state
//   busy/done     : burst running (RUN/STALL) / burst complete (DONE)
//   wr_count      : words pushed in the current burst
// Optional build macro LFSR_FEEDER_PARITY_EN adds:
//   wr_parity     : XOR-reduce of wr_data, registered with wr_en
//   parity_err    : sticky flag, set if lfsr_q is ever all-zero
//
// state | meaning
// IDLE  | no burst; waiting for start edge
// RUN   | burst active, one push per tick
// STALL | tick hit a full FIFO; wait for space, then RUN
// DONE  | BURST_LEN words pushed; waiting for next start edge
module lfsr_fifo_feeder
   import fifo_lab_pkg::*;
#(
   parameter int               WIDTH       = 16,
   parameter logic [WIDTH-1:0] SEED        = DEFAULT_SEED,
   parameter int               BURST_LEN   = 32,
   parameter int               SYNC_STAGES = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             tick_in,
   input  logic             start,
   input  logic             enable,
   input  logic             seed_load,
   input  logic             fifo_full,
   output logic             wr_en,
   output logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] lfsr_q,
   output logic             busy,
   output logic             done,
   output logic [5:0]       wr_count
`ifdef LFSR_FEEDER_PARITY_EN
   ,
   output logic             wr_parity,
   output logic             parity_err
`endif
);

   localparam logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_TAPS);
   localparam logic [5:0]       BURST = 6'(BURST_LEN);

   logic tick_p;
   logic start_p;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] lfsr_d;
   logic [WIDTH-1:0] wr_data_q, wr_data_d;
   logic             wr_en_q, wr_en_d;
   logic [5:0]       count_q, count_d;
   logic             push;

   edge_sync_pulse #(.STAGES(SYNC_STAGES)) u_tick_sync (
      .clock   (clock),
      .reset   (reset),
      .d_i     (tick_in),
      .pulse_o (tick_p)
   );

   edge_sync_pulse #(.STAGES(0)) u_start_edge (
      .clock   (clock),
      .reset   (reset),
      .d_i     (start),
      .pulse_o (start_p)
   );

   always_comb begin
      state_d   = state_q;
      lfsr_d    = lfsr_q;
      count_d   = count_q;
      wr_en_d   = 1'b0;
      wr_data_d = wr_data_q;
      push      = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            if (start_p) begin
               state_d = RUN;
               count_d = '0;
            end
         end
         RUN: begin
            if (tick_p) begin
               if (fifo_full)   state_d = STALL;
               else if (enable) push    = 1'b1;
            end
         end
         STALL: begin
            // Ticks seen here are dropped on purpose; only a fresh tick in
            // RUN pushes.
            if (!fifo_full) state_d = RUN;
         end
         default: state_d = IDLE;
      endcase

      if (push) begin
         wr_en_d   = 1'b1;
         wr_data_d = lfsr_q;
         lfsr_d    = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
         if (count_q != BURST) count_d = count_q + 6'd1;
         if (count_q + 6'd1 == BURST) state_d = DONE;
      end

      // All-zero is a lock-up state of the LFSR; recover from it.
      if (lfsr_q == '0) lfsr_d = SEED;

      if (!seed_load) begin
         state_d = IDLE;
         lfsr_d  = SEED;
         count_d = '0;
         wr_en_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         lfsr_q    <= SEED;
         count_q   <= '0;
         wr_en_q   <= 1'b0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         lfsr_q    <= lfsr_d;
         count_q   <= count_d;
         wr_en_q   <= wr_en_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign wr_en    = wr_en_q;
   assign wr_data  = wr_data_q;
   assign wr_count = count_q;
   assign busy     = (state_q == RUN) || (state_q == STALL);
   assign done     = (state_q == DONE);

`ifdef LFSR_FEEDER_PARITY_EN
   logic parity_q;
   logic perr_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         parity_q <= 1'b0;
         perr_q   <= 1'b0;
      end else begin
         if (push && seed_load) parity_q <= ^lfsr_q;
         if (!seed_load)          perr_q <= 1'b0;
         else if (lfsr_q == '0)   perr_q <= 1'b1;
      end
   end

   assign wr_parity  = parity_q;
   assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_lfsr_fifo_feeder.sv
module tb_lfsr_fifo_feeder;

   localparam logic [15:0] SEED = 16'h0001;
   localparam int          BL   = 32;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        tick_in = 1'b0;
   logic        start = 1'b0;
   logic        enable = 1'b1;
   logic        seed_load = 1'b1;
   logic        fifo_full = 1'b0;
   logic        wr_en;
   logic [15:0] wr_data;
   logic [15:0] lfsr_q;
   logic        busy;
   logic        done;
   logic [5:0]  wr_count;
`ifdef LFSR_FEEDER_PARITY_EN
   logic        wr_parity;
   logic        parity_err;
`endif

   lfsr_fifo_feeder dut (
      .clock     (clock),
      .reset     (reset),
      .tick_in   (tick_in),
      .start     (start),
      .enable    (enable),
      .seed_load (seed_load),
      .fifo_full (fifo_full),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .lfsr_q    (lfsr_q),
      .busy      (busy),
      .done      (done),
      .wr_count  (wr_count)
`ifdef LFSR_FEEDER_PARITY_EN
      ,
      .wr_parity (wr_parity),
      .parity_err(parity_err)
`endif
   );

   always #10 clock = ~clock;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [15:0] exp_q[$];
   logic        exp_par_q[$];

   // Reference model: 0 idle, 1 run, 2 stall, 3 done
   logic [15:0] m_lfsr = SEED;
   int          m_count = 0;
   int          m_mode  = 0;

   function automatic logic [15:0] poly_step(input logic [15:0] x);
      int v, fb;
      v  = int'(x);
      fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) % 2;
      return 16'((v * 2 + fb) % 65536);
   endfunction

   function automatic logic xor_parity(input logic [15:0] x);
      int ones = 0;
      for (int i = 0; i < 16; i++) ones += (int'(x) >> i) % 2;
      return logic'(ones % 2);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT pushes.
   logic        prev_en = 1'b0;
   logic [15:0] mon_d;
   logic        mon_p;
   always @(negedge clock) begin
      if (reset && wr_en === 1'b1) begin
         check("wr_en_gap", prev_en, 0);
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_push: wr_data=%h expected no push at %0t", wr_data, $time);
         end else begin
            mon_d = exp_q.pop_front();
            mon_p = exp_par_q.pop_front();
            check("wr_data", wr_data, mon_d);
`ifdef LFSR_FEEDER_PARITY_EN
            check("wr_parity", wr_parity, mon_p);
`endif
         end
      end
      prev_en = wr_en;
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic do_tick();
      if (m_mode == 1) begin
         if (fifo_full) m_mode = 2;
         else if (enable) begin
            exp_q.push_back(m_lfsr);
            exp_par_q.push_back(xor_parity(m_lfsr));
            m_lfsr = poly_step(m_lfsr);
            m_count++;
            if (m_count == BL) m_mode = 3;
         end
      end
      @(posedge clock);
      #($urandom_range(1, 18));
      tick_in = 1'b1;
      wait_cyc(5);
      tick_in = 1'b0;
      wait_cyc(3);
   endtask

   task automatic do_start();
      if (m_mode == 0 || m_mode == 3) begin
         m_mode  = 1;
         m_count = 0;
      end
      @(posedge clock);
      #1 start = 1'b1;
      wait_cyc(2);
      start = 1'b0;
      wait_cyc(1);
   endtask

   task automatic do_seed();
      m_lfsr  = SEED;
      m_count = 0;
      m_mode  = 0;
      @(posedge clock);
      #1 seed_load = 1'b0;
      wait_cyc(1);
      seed_load = 1'b1;
      wait_cyc(1);
   endtask

   task automatic set_full(input logic v);
      fifo_full = v;
      wait_cyc(2);
      if (!v && m_mode == 2) m_mode = 1;
   endtask

   task automatic check_state(input string tag);
      check({tag, ".lfsr_q"}, lfsr_q, m_lfsr);
      check({tag, ".wr_count"}, wr_count, m_count);
      check({tag, ".busy"}, busy, (m_mode == 1 || m_mode == 2));
      check({tag, ".done"}, done, (m_mode == 3));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [15:0] held_l;
      int          held_c;
      int          r;

      // Reset values while reset is held
      #25;
      check("rst.wr_en", wr_en, 0);
      check("rst.wr_data", wr_data, 0);
      check("rst.lfsr_q", lfsr_q, SEED);
      check("rst.busy", busy, 0);
      check("rst.done", done, 0);
      check("rst.wr_count", wr_count, 0);
      #10 reset = 1'b1;
      wait_cyc(2);

      // Start, 11 ticks
      do_start();
      repeat (11) do_tick();
      check("t11.lfsr_q", lfsr_q, 16'h0801);
      check("t11.wr_count", wr_count, 11);
      check("t11.busy", busy, 1);
      check_state("t11");

      // Complete the burst, then extra ticks must not push
      repeat (21) do_tick();
      check("burst.done", done, 1);
      check("burst.busy", busy, 0);
      check("burst.wr_count", wr_count, 32);
      repeat (2) do_tick();
      check_state("post_done");
      check("post_done.pending", exp_q.size(), 0);

      // Stall on 5th tick
      do_seed();
      do_start();
      repeat (4) do_tick();
      set_full(1'b1);
      do_tick();
      check("stall.lfsr_q", lfsr_q, 16'h0010);
      check("stall.busy", busy, 1);
      check_state("stall");
      set_full(1'b0);
      do_tick();
      check_state("unstall");

      // enable low for 3 ticks
      held_l = lfsr_q;
      held_c = int'(wr_count);
      enable = 1'b0;
      wait_cyc(1);
      repeat (3) do_tick();
      check("dis.lfsr_q", lfsr_q, held_l);
      check("dis.wr_count", wr_count, held_c);
      enable = 1'b1;
      wait_cyc(1);
      repeat (2) do_tick();
      check_state("reen");

      // seed_load coinciding with tick_p
      @(posedge clock);
      #1 tick_in = 1'b1;
      @(posedge clock);
      @(posedge clock);
      #1 seed_load = 1'b0;
      @(posedge clock);
      #1 seed_load = 1'b1;
      m_lfsr = SEED; m_count = 0; m_mode = 0;
      check("seedtick.wr_en", wr_en, 0);
      check_state("seedtick");
      wait_cyc(4);
      tick_in = 1'b0;
      wait_cyc(3);
      do_start();
      do_tick();
      check_state("restart");

      // Randomised phase
      for (int i = 0; i < 150; i++) begin
         r = $urandom_range(0, 99);
         if (r < 4) do_seed();
         else if (r < 10 || ((m_mode == 0 || m_mode == 3) && r < 40)) do_start();
         else if (r < 18) begin enable = ~enable; wait_cyc(1); end
         else if (r < 26) set_full(($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0);
         else do_tick();
      end
      set_full(1'b0);
      enable = 1'b1;
      wait_cyc(1);
      check_state("random");
      check("random.pending", exp_q.size(), 0);

      // Async reset while a push is on the output
      do_start();
      repeat (3) do_tick();
      @(posedge clock);
      #1 tick_in = 1'b1;
      repeat (3) @(posedge clock);
      #5 reset = 1'b0;
      #1;
      check("arst.wr_en", wr_en, 0);
      check("arst.wr_data", wr_data, 0);
      check("arst.lfsr_q", lfsr_q, SEED);
      check("arst.busy", busy, 0);
      check("arst.done", done, 0);
      check("arst.wr_count", wr_count, 0);
      m_lfsr = SEED; m_count = 0; m_mode = 0;
      tick_in = 1'b0;
      wait_cyc(2);
      reset = 1'b1;
      wait_cyc(2);
      do_start();
      repeat (12) do_tick();
      check_state("after_arst");
`ifdef LFSR_FEEDER_PARITY_EN
      check("parity_err", parity_err, 0);
`endif
      check("final.pending", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
